// File: rtl/arm_fetch_unit.sv
// -----------------------------------------------------------------------------
// arm_fetch_unit
// Instruction fetch stage feeding the ARM data-processing datapath.
// Holds the PC and issues word fetches to instruction memory. At most one
// request is outstanding at a time. Returned words are buffered in a small
// FIFO, and the consumer reads them through a valid/ready handshake.
// A downstream redirect loads a new PC and flushes everything in flight.
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous, active-high reset
//   imem_req       - fetch request, held high until imem_rvalid
//   imem_addr      - word-aligned fetch address, stable while imem_req high
//   imem_rvalid    - memory response valid (may coincide with imem_req)
//   imem_rdata     - instruction word from memory
//   Instr          - FIFO head instruction (0 when empty)
//   instr_pc       - PC of FIFO head (0 when empty)
//   instr_valid    - head valid and no redirect this cycle
//   instr_ready    - consumer accepts head
//   redirect_valid - load redirect_pc and flush
//   redirect_pc    - new PC, low two bits forced to zero
// -----------------------------------------------------------------------------
module arm_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int               PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PONE_C  = PTR_W'(1);
    localparam logic [31:0]      RST_PC_C = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DROP = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      fetch_pc_next_s;
    logic [31:0]      addr_r;
    logic [31:0]      data_mem_r [BUF_DEPTH];
    logic [31:0]      pc_mem_r   [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Handshake decode, occupancy update and next fetch PC.
    always_comb begin
        empty_s     = (count_r == {CNT_W{1'b0}});
        // A redirect hides the head so nothing is popped while flushing.
        instr_valid = !empty_s && !redirect_valid;
        pop_s       = instr_valid && instr_ready;
        // Responses that coincide with a redirect belong to the old stream.
        push_s      = (state_r == ST_REQ) && imem_rvalid && !redirect_valid;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
        if (redirect_valid) begin
            fetch_pc_next_s = redirect_pc & 32'hFFFF_FFFC;
        end else if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;   // wraps modulo 2^32
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!redirect_valid && (count_r < DEPTH_C)) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    // Without the response yet, it must still be swallowed.
                    state_next_s = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    // Keep streaming only if a slot remains after this push.
                    state_next_s = (count_next_s < DEPTH_C) ? ST_REQ : ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, fetch PC and registered request address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RST_PC_C;
            addr_r     <= RST_PC_C;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            // The address only moves when a new request begins, so DROP
            // keeps presenting the stale address of the abandoned fetch.
            if (state_next_s == ST_REQ) begin
                addr_r <= fetch_pc_next_s;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PONE_C;
            end
            count_r <= count_next_s;
        end
    end

    // FIFO storage: instruction word and the PC it was fetched from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
        end
    end

    // Output drive: head comes straight from FIFO registers.
    always_comb begin
        imem_req  = (state_r != ST_IDLE);
        imem_addr = addr_r;
        if (empty_s) begin
            Instr    = 32'h0000_0000;
            instr_pc = 32'h0000_0000;
        end else begin
            Instr    = data_mem_r[rd_ptr_r];
            instr_pc = pc_mem_r[rd_ptr_r];
        end
    end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_arm_fetch_unit
// Directed bench for arm_fetch_unit. Instance a uses RESET_PC=0. Instance b
// uses RESET_PC=FFFF_FFF8 to exercise PC wrap. Both instances share the
// memory, consumer and redirect inputs, and each has its own reset.
// -----------------------------------------------------------------------------
module tb_arm_fetch_unit;

    logic        clk;
    logic        a_reset;
    logic        b_reset;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        a_imem_req;
    logic [31:0] a_imem_addr;
    logic [31:0] a_instr;
    logic [31:0] a_instr_pc;
    logic        a_instr_valid;
    logic        b_imem_req;
    logic [31:0] b_imem_addr;
    logic [31:0] b_instr;
    logic [31:0] b_instr_pc;
    logic        b_instr_valid;

    int checks;
    int errors;
    int pushes;
    logic [31:0] b_exp [4];

    arm_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .imem_req(a_imem_req), .imem_addr(a_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(a_instr), .instr_pc(a_instr_pc), .instr_valid(a_instr_valid),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    arm_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(b_instr), .instr_pc(b_instr_pc), .instr_valid(b_instr_valid),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, then return memory/redirect idle.
    task automatic cyc(input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
        imem_rvalid    = rv;
        imem_rdata     = rd;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pushes = 0;
        a_reset = 1'b0;
        b_reset = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0000_0000;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        b_exp[0] = 32'hFFFF_FFF8;
        b_exp[1] = 32'hFFFF_FFFC;
        b_exp[2] = 32'h0000_0000;
        b_exp[3] = 32'h0000_0004;
        #1;
        a_reset = 1'b1;
        b_reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", 32'(a_imem_req), 32'd0);
        chk("rst_valid", 32'(a_instr_valid), 32'd0);
        chk("rst_instr", a_instr, 32'h0000_0000);
        chk("rst_pc", a_instr_pc, 32'h0000_0000);

        // Streaming with zero-wait memory and an always-ready consumer.
        a_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_req", 32'(a_imem_req), 32'd1);
        chk("first_addr", a_imem_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hE000_0000 ^ (32'd4 * 32'(i)), 1'b1, 1'b0, 32'h0);
            chk("stream_addr", a_imem_addr, 32'd4 * 32'(i + 1));
            chk("stream_valid", 32'(a_instr_valid), 32'd1);
            chk("stream_instr", a_instr, 32'hE000_0000 ^ (32'd4 * 32'(i)));
            chk("stream_pc", a_instr_pc, 32'd4 * 32'(i));
        end

        // Stalled consumer: exactly two words fetched, then request drops.
        a_reset = 1'b1;
        #1;
        @(posedge clk);
        #2;
        a_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_start_addr", a_imem_addr, 32'h0000_0000);
        for (int i = 0; i < 10; i++) begin
            if (a_imem_req) pushes++;
            cyc(a_imem_req, a_imem_addr ^ 32'hE000_0000, 1'b0, 1'b0, 32'h0);
            if (i >= 1) chk("stall_req_low", 32'(a_imem_req), 32'd0);
        end
        chk("stall_fetch_cnt", 32'(pushes), 32'd2);
        chk("stall_instr", a_instr, 32'hE000_0000);
        chk("stall_pc", a_instr_pc, 32'h0000_0000);
        chk("stall_valid", 32'(a_instr_valid), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("drain_instr", a_instr, 32'hE000_0004);
        chk("drain_pc", a_instr_pc, 32'h0000_0004);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("drain_empty", 32'(a_instr_valid), 32'd0);
        chk("resume_req", 32'(a_imem_req), 32'd1);
        chk("resume_addr", a_imem_addr, 32'h0000_0008);

        // Redirect while fetch of 8 is outstanding; response 3 cycles later.
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
        chk("drop_req", 32'(a_imem_req), 32'd1);
        chk("drop_addr", a_imem_addr, 32'h0000_0008);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("drop_hold_addr", a_imem_addr, 32'h0000_0008);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        chk("drop_done_req", 32'(a_imem_req), 32'd0);
        chk("drop_no_push", 32'(a_instr_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("redir_addr", a_imem_addr, 32'h0000_0100);
        cyc(1'b1, 32'hE000_0100, 1'b1, 1'b0, 32'h0);
        chk("redir_instr", a_instr, 32'hE000_0100);
        chk("redir_pc", a_instr_pc, 32'h0000_0100);

        // Fill the FIFO to two words, then redirect: flush and refetch.
        cyc(1'b1, 32'hE000_0104, 1'b0, 1'b0, 32'h0);
        chk("full_req", 32'(a_imem_req), 32'd0);
        chk("full_head", a_instr, 32'hE000_0100);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        chk("redir_valid_low", 32'(a_instr_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
        chk("flush_valid", 32'(a_instr_valid), 32'd0);
        chk("flush_instr", a_instr, 32'h0000_0000);
        chk("flush_req", 32'(a_imem_req), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("flush_refetch", a_imem_addr, 32'h0000_0200);

        // Redirect coinciding with rvalid: response dropped, fetch at target.
        cyc(1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0302);
        chk("coinc_valid", 32'(a_instr_valid), 32'd0);
        chk("coinc_req", 32'(a_imem_req), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("coinc_addr", a_imem_addr, 32'h0000_0300);

        // Asynchronous reset mid-request with a word buffered.
        cyc(1'b1, 32'hE000_0300, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_valid", 32'(a_instr_valid), 32'd1);
        chk("pre_rst_req", 32'(a_imem_req), 32'd1);
        a_reset = 1'b1;
        #1;
        chk("arst_req", 32'(a_imem_req), 32'd0);
        chk("arst_valid", 32'(a_instr_valid), 32'd0);
        chk("arst_instr", a_instr, 32'h0000_0000);
        chk("arst_pc", a_instr_pc, 32'h0000_0000);
        #1;
        a_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_first_addr", a_imem_addr, 32'h0000_0000);
        chk("arst_first_req", 32'(a_imem_req), 32'd1);

        // PC wrap on instance b with zero-wait memory.
        b_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_first_addr", b_imem_addr, b_exp[0]);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, b_exp[i] ^ 32'hE000_0000, 1'b1, 1'b0, 32'h0);
            chk("wrap_instr", b_instr, b_exp[i] ^ 32'hE000_0000);
            chk("wrap_pc", b_instr_pc, b_exp[i]);
            chk("wrap_addr", b_imem_addr, b_exp[i + 1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
